// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 24Cxx-style serial EEPROM with a 1-byte word address.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low through sda_oe_o.
module i2c_eeprom_slave #(
  parameter logic [6:0]  ADDRESS   = 7'b1010_000,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o
);

  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_inc;
  logic               rw_q, rw_d;
  logic               sda_oe_q, sda_oe_d;
  logic               mem_we;
  logic [7:0]         mem_q [MEM_DEPTH];

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;
  logic scl_rise, scl_fall, start, stop, byte_done;
  logic [7:0] rx_byte, rd_byte;

  // Two-flop synchronisers plus a previous-value stage; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start     = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop      = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign rd_byte   = mem_q[ptr_q];
  assign ptr_inc   = (ptr_q == PTR_W'(MEM_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign byte_done = scl_rise && (bitcnt_q == CNT_W'(7));
  assign sda_oe_o  = sda_oe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'hFF;
    end else if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

  // Bus conditions override everything; otherwise bits move on SCL edges.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    mem_we   = 1'b0;
    if (start) begin
      state_d  = DEV;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;
        DEV, WADDR, WDATA: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
          if (byte_done) begin
            bitcnt_d = '0;
            if (state_q == DEV) begin
              if (rx_byte[7:1] == ADDRESS) begin
                state_d = DEV_ACK;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == WADDR) begin
              ptr_d   = PTR_W'(rx_byte);
              state_d = WADDR_ACK;
            end else begin
              mem_we  = 1'b1;
              ptr_d   = ptr_inc;
              state_d = WDATA_ACK;
            end
          end
        end
        // First fall drives the ACK, second fall releases it and moves on.
        DEV_ACK, WADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == DEV_ACK && rw_q) begin
              state_d  = RDATA;
              shift_d  = rd_byte;
              bitcnt_d = '0;
              sda_oe_d = ~rd_byte[7];
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == DEV_ACK) ? WADDR : WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (bitcnt_q == CNT_W'(8)) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_inc;
              state_d  = RACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              state_d  = RDATA;
              shift_d  = rd_byte;
              bitcnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: open-drain bus master, byte-level EEPROM model,
// and a scoreboard that pairs observed bus results with queued expectations.
module tb_i2c_eeprom_slave;

  logic clk;
  logic rst;
  logic scl;
  logic m_sda;
  logic sda_oe;
  logic bus_sda;

  assign bus_sda = m_sda & ~sda_oe;

  i2c_eeprom_slave dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl),
    .sda_i    (bus_sda),
    .sda_oe_o (sda_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] exp_q [$];
  string      exp_name_q [$];
  logic [7:0] obs_q [$];
  int         total = 0;
  int         bad   = 0;

  logic [7:0] mdl_mem [256];
  int         mdl_ptr;
  logic [7:0] wbuf [4];

  task automatic expect_v(input string nm, input logic [7:0] v);
    exp_q.push_back(v);
    exp_name_q.push_back(nm);
  endtask

  task automatic observe(input logic [7:0] v);
    obs_q.push_back(v);
  endtask

  // Scoreboard monitor: pairs each observation with the oldest expectation.
  initial begin
    logic [7:0] o, e;
    string nm;
    forever begin
      @(negedge clk);
      while (obs_q.size() != 0) begin
        o = obs_q.pop_front();
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_obs: got %02h with no expectation queued", o);
        end else begin
          e  = exp_q.pop_front();
          nm = exp_name_q.pop_front();
          if (o !== e) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", nm, o, e);
          end
        end
      end
    end
  end

  function automatic void mdl_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'hFF;
    mdl_ptr = 0;
  endfunction

  // One SCL clock: SDA set mid-low, sampled mid-high; ends just after SCL falls.
  task automatic bit_slot(input logic b, output logic s);
    #100 m_sda = b;
    #100 scl = 1'b1;
    #100 s = bus_sda;
    #100 scl = 1'b0;
  endtask

  task automatic i2c_start();
    #100 m_sda = 1'b1;
    #100 scl = 1'b1;
    #100 m_sda = 1'b0;
    #100 scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #100 m_sda = 1'b0;
    #100 scl = 1'b1;
    #100 m_sda = 1'b1;
    #100;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic s;
    for (int i = 7; i >= 0; i--) bit_slot(b[i], s);
    bit_slot(1'b1, s);
    expect_v(nm, {7'b0, exp_ack});
    observe({7'b0, s});
  endtask

  task automatic recv_byte(input logic nack, input string nm);
    logic [7:0] d;
    logic s;
    expect_v(nm, mdl_mem[mdl_ptr]);
    mdl_ptr = (mdl_ptr + 1) % 256;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, s);
      d[i] = s;
    end
    bit_slot(nack, s);
    observe(d);
  endtask

  task automatic set_addr(input logic [7:0] addr);
    i2c_start();
    send_byte(8'hA0, 1'b0, "devw_ack");
    send_byte(addr, 1'b0, "waddr_ack");
    mdl_ptr = int'(addr);
  endtask

  task automatic wr_txn(input logic [7:0] addr, input int n);
    set_addr(addr);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], 1'b0, "wdata_ack");
      mdl_mem[mdl_ptr] = wbuf[i];
      mdl_ptr = (mdl_ptr + 1) % 256;
    end
    i2c_stop();
  endtask

  // Read n bytes from the current pointer; the last byte is NACKed.
  task automatic rd_txn(input int n);
    i2c_start();
    send_byte(8'hA1, 1'b0, "devr_ack");
    for (int i = 0; i < n; i++) recv_byte(i == n - 1, "rdata");
    i2c_stop();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s;
    logic [7:0] addr;
    int n;
    rst   = 1'b1;
    scl   = 1'b1;
    m_sda = 1'b1;
    mdl_reset();
    repeat (4) @(negedge clk);
    expect_v("reset_oe", 8'h00);
    observe({7'b0, sda_oe});
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Random read of a fresh device returns erased contents.
    set_addr(8'h00);
    rd_txn(1);

    // Write then read back one byte.
    wbuf[0] = 8'h3C;
    wr_txn(8'h05, 1);
    set_addr(8'h05);
    rd_txn(1);

    // Wrong device address: no ACK, following byte ignored.
    i2c_start();
    send_byte(8'hA2, 1'b1, "wrong_dev_nack");
    send_byte(8'h77, 1'b1, "ignored_byte_nack");
    i2c_stop();
    set_addr(8'h00);
    rd_txn(1);

    // Sequential write and read across the 0xFF -> 0x00 wrap.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    wr_txn(8'hFE, 3);
    set_addr(8'hFE);
    rd_txn(3);

    // Current-address read, then STOP in the middle of a read byte.
    rd_txn(1);
    i2c_start();
    send_byte(8'hA1, 1'b0, "devr_ack");
    for (int i = 0; i < 4; i++) bit_slot(1'b1, s);
    #100 m_sda = 1'b0;
    #100 scl = 1'b1;
    #100 m_sda = 1'b1;
    #40;
    expect_v("stop_release_oe", 8'h00);
    observe({7'b0, sda_oe});
    #60;

    // Reset after four data bits: bus released, nothing written.
    set_addr(8'h10);
    for (int i = 7; i >= 4; i--) bit_slot(i[0], s);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_v("rst_mid_data_oe", 8'h00);
    observe({7'b0, sda_oe});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    i2c_stop();
    set_addr(8'h10);
    rd_txn(1);

    // Reset while the slave is holding an ACK low.
    set_addr(8'h20);
    addr = 8'hC3;
    for (int i = 7; i >= 0; i--) bit_slot(addr[i], s);
    #40;
    expect_v("ack_driven_oe", 8'h01);
    observe({7'b0, sda_oe});
    rst = 1'b1;
    #10;
    expect_v("rst_mid_ack_oe", 8'h00);
    observe({7'b0, sda_oe});
    #20 rst = 1'b0;
    mdl_reset();
    i2c_stop();
    set_addr(8'h20);
    rd_txn(1);

    // Randomised write/read traffic against the reference model.
    for (int it = 0; it < 6; it++) begin
      addr = 8'($urandom_range(0, 255));
      n    = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      wr_txn(addr, n);
      set_addr(addr);
      if ($urandom_range(0, 1) == 1) i2c_stop();
      rd_txn(n);
    end

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect: got %0d unmatched expectations want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
